// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: ctrl/data bundles with valid/ready handshake and a 2-entry skid buffer.
// Optional PIPE_STAGE_STATS_EN adds saturating stall/bubble/flush counters.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W              = 24,
  parameter int unsigned DATA_W              = 20,
  parameter int unsigned CLEAR_DATA_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Bit 0 = main valid, bit 1 = skid valid; outputs come straight off these flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic               accept_c;
  logic               drain_c;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  assign accept_c = in_valid & ~state_q[1];
  assign drain_c  = state_q[0] & out_ready;

  // Next-state and entry update; flush overrides normal operation.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (drain_c && accept_c) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (drain_c) begin
          main_ctrl_d = '0;
          state_d     = ST_EMPTY;
        end else if (accept_c) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_SKID;
        end
      end
      ST_SKID: begin
        if (drain_c) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          state_d     = ST_FULL;
        end
      end
      default: begin
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        state_d     = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end else begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // Saturating event counters; only rst clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (state_q[0] && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!state_q[0] && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default instance and a CLEAR_DATA_ON_FLUSH=0 instance share stimulus,
// checked against a queue-based model of the two-entry stage.
module tb_pipe_stage_reg;
  localparam int unsigned CW = 24;
  localparam int unsigned DW = 20;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, nc_in_ready, nc_out_valid;
  logic [CW-1:0] out_ctrl, nc_out_ctrl;
  logic [DW-1:0] out_data, nc_out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]   stall_cnt, bubble_cnt, flush_cnt;
  logic [15:0]   nc_stall_cnt, nc_bubble_cnt, nc_flush_cnt;
  int unsigned   e_stall, e_bubble, e_flush;
`endif

  int total = 0;
  int bad   = 0;

  // Model: accepted-but-not-drained beats in order, head is what the output shows.
  logic [CW-1:0] mq_c[$];
  logic [DW-1:0] mq_d[$];
  logic [DW-1:0] nc_shown;
  bit            was_flush, was_rst;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_ctrl(nc_out_ctrl), .out_data(nc_out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(nc_stall_cnt), .bubble_cnt(nc_bubble_cnt), .flush_cnt(nc_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
  endfunction

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock: advance the model with pre-edge inputs, then compare #1 after the edge.
  task automatic tick();
    int  n;
    bit  acc, drn;
    @(posedge clk);
    n = mq_c.size();
    was_flush = flush && !rst;
    was_rst   = rst;
    if (rst) begin
      mq_c.delete();
      mq_d.delete();
      nc_shown = '0;
`ifdef PIPE_STAGE_STATS_EN
      e_stall = 0; e_bubble = 0; e_flush = 0;
`endif
    end else begin
`ifdef PIPE_STAGE_STATS_EN
      if (n > 0 && !out_ready) e_stall = sat_inc(e_stall);
      if (n == 0) e_bubble = sat_inc(e_bubble);
      if (flush) e_flush = sat_inc(e_flush);
`endif
      acc = in_valid && (n < 2);
      drn = (n > 0) && out_ready;
      if (flush) begin
        mq_c.delete();
        mq_d.delete();
      end else begin
        if (drn) begin
          void'(mq_c.pop_front());
          void'(mq_d.pop_front());
        end
        if (acc) begin
          mq_c.push_back(in_ctrl);
          mq_d.push_back(in_data);
        end
      end
    end
    if (mq_c.size() > 0) nc_shown = mq_d[0];
    #1;
    chk("in_ready", 32'(in_ready), 32'(mq_c.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq_c.size() > 0));
    chk("out_ctrl", 32'(out_ctrl), (mq_c.size() > 0) ? 32'(mq_c[0]) : 32'd0);
    chk("nc_in_ready", 32'(nc_in_ready), 32'(mq_c.size() < 2));
    chk("nc_out_valid", 32'(nc_out_valid), 32'(mq_c.size() > 0));
    chk("nc_out_ctrl", 32'(nc_out_ctrl), (mq_c.size() > 0) ? 32'(mq_c[0]) : 32'd0);
    if (mq_c.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(mq_d[0]));
      chk("nc_out_data", 32'(nc_out_data), 32'(mq_d[0]));
    end else if (was_rst || was_flush) begin
      chk("out_data_cleared", 32'(out_data), 32'd0);
      chk("nc_out_data_held", 32'(nc_out_data), 32'(nc_shown));
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(e_bubble));
    chk("flush_cnt", 32'(flush_cnt), 32'(e_flush));
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset for two cycles.
    tick(); tick();
    rst = 1'b0;
    tick();

    // Streaming: one beat per cycle, one-cycle latency.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, CW'(i), DW'(32'h100 + i), 1'b1, 1'b0);
      tick();
      chk("stream_out", 32'(out_ctrl), 32'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();

    // Back-pressure: A1 in main, A2 in skid, A3 held upstream.
    drive(1'b1, CW'(24'hA1), DW'(20'h000A1), 1'b0, 1'b0); tick();
    drive(1'b1, CW'(24'hA2), DW'(20'h000A2), 1'b0, 1'b0); tick();
    drive(1'b1, CW'(24'hA3), DW'(20'h000A3), 1'b0, 1'b0); tick();
    chk("bp_main", 32'(out_ctrl), 32'h0000A1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, CW'(24'hA3), DW'(20'h000A3), 1'b1, 1'b0); tick();
    chk("bp_second", 32'(out_ctrl), 32'h0000A2);
    tick();
    chk("bp_third", 32'(out_ctrl), 32'h0000A3);
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Flush while in SKID with a beat offered upstream.
    drive(1'b1, CW'(24'h11), DW'(20'h00011), 1'b0, 1'b0); tick();
    drive(1'b1, CW'(24'h22), DW'(20'h00022), 1'b0, 1'b0); tick();
    drive(1'b1, CW'(24'h33), DW'(20'h00033), 1'b0, 1'b1); tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(out_ctrl), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_leak", 32'(out_valid), 32'd0);
    end

    // Data hold vs clear on flush.
    drive(1'b1, CW'(24'h5A), DW'(20'h5A5A5), 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    chk("nc_hold_data", 32'(nc_out_data), 32'h5A5A5);
    chk("clr_data", 32'(out_data), 32'd0);

    // Flush held several cycles with upstream valid.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CW'(24'h77 + i), DW'(i), 1'b1, 1'b1);
      tick();
      chk("flush_held_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive(1'(($urandom_range(0, 2)) != 0), CW'($urandom), DW'($urandom),
            1'(($urandom_range(0, 2)) != 0), ($urandom_range(0, 19) == 0));
      tick();
    end
    rst = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    drive(1'b1, CW'(24'h44), DW'(20'h44), 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(); tick(); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick(); tick();
    chk("stats_stall", 32'(stall_cnt), 32'd3);
    chk("stats_flush", 32'(flush_cnt), 32'd1);
    chk("stats_bubble", 32'(bubble_cnt), 32'd3);
    drive(1'b1, CW'(24'h55), DW'(20'h55), 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    chk("stats_stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the successor to the fixed-field inter-stage registers. Carries a control bundle and a data bundle between any two pipeline stages. Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered, no beat is lost under back-pressure, and flush inserts a clean bubble. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
CTRL_W, 24, width of control bundle (reg_write, mem_read, alu_op, mux selects, ...); forced to zero on bubble/flush
DATA_W, 20, width of data bundle (operands, register indices)
CLEAR_DATA_ON_FLUSH, 1, 1 = data bundle zeroed on flush; 0 = data bundle held (saves resets)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat; equals NOT skid_valid (register-driven)
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts main entry
out_ctrl  out  CTRL_W  main entry control; all-zero whenever out_valid=0
out_data  out  DATA_W  main entry data

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each has a valid bit.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Reset (rst=1 at clock edge): both valids=0; out_ctrl=0; out_data=0; skid contents=0. in_ready=1 from the first cycle after reset.
- Priority: rst > flush > normal operation.
- States:
  - EMPTY: main and skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- EMPTY: Accept -> main<=in, go to FULL. Latency is 1 cycle from input to output.
- FULL:
  - Drain & Accept -> main<=in, stay in FULL.
  - Drain & !Accept -> go to EMPTY; out_ctrl zeroed.
  - !Drain & Accept -> skid<=in, go to SKID.
  - Otherwise hold.
- SKID: in_ready=0.
  - Drain -> main<=skid, skid invalid, go to FULL; in_ready=1 next cycle.
  - Otherwise hold.
- Stability: while out_valid=1 & out_ready=0, out_ctrl and out_data hold constant.
- Ordering: beats leave in acceptance order; none dropped or duplicated except by flush.
- Flush at an edge:
  - Both valids go to 0, out_ctrl and skid ctrl go to 0, data is zeroed per CLEAR_DATA_ON_FLUSH.
  - Any same-cycle Accept is discarded; a same-cycle Drain still counts as completed downstream.
  - Next cycle: EMPTY, in_ready=1.
- Flush held for N cycles produces N+ bubble cycles; in_ready stays 1 throughout.
- rst asserted mid-operation discards all entries exactly like flush, and also clears data unconditionally.
- No combinational path from in_* to out_*. in_ready depends only on state, not on out_ready.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined:
  - Adds outputs stall_cnt[15:0] (increments on cycles with out_valid & !out_ready), bubble_cnt[15:0] (increments on cycles with !out_valid) and flush_cnt[15:0] (increments on cycles with flush=1).
  - All three saturate at 16'hFFFF.
  - Cleared only by rst; flush does not clear them.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1; with PIPE_STAGE_STATS_EN, all counters=0.
- Streaming: out_ready=1; feed ctrl 0x000001..0x000005 on consecutive cycles -> same values on out_ctrl one cycle later each, in_ready stays 1, no gaps.
- Back-pressure: hold out_ready=0 while feeding 0xA1, 0xA2, 0xA3 -> 0xA1 on output, 0xA2 in skid, in_ready=0, 0xA3 held upstream. Then out_ready=1 -> outputs 0xA1, 0xA2, 0xA3 in order, nothing lost.
- Flush in SKID: main 0x11 and skid 0x22 with in_valid=1 carrying 0x33, assert flush one cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x11, 0x22 and 0x33 never appear at the output.
- CLEAR_DATA_ON_FLUSH=0: flush with out_data=0x5A5A5 -> out_valid=0, out_ctrl=0, out_data stays 0x5A5A5.
- Stats (macro on): 3 stall cycles, 1 flush, 2 idle cycles -> stall_cnt=3, flush_cnt=1, bubble_cnt equals the cycle count with out_valid=0 (including the flush bubble); drive 70000 stall cycles -> stall_cnt=0xFFFF.
